// File: rtl/brick_draw_queue_if.sv
// Request/dispatch bundle between collision logic, brick_draw_queue and brick_draw.
// master drives requests and observes dispatch; slave is the queue itself.
interface brick_draw_queue_if;
    logic       req_valid;
    logic [9:0] req_x;
    logic [9:0] req_y;
    logic [1:0] req_health;
    logic       req_ready;
    logic       go_draw;
    logic [9:0] brickx;
    logic [9:0] bricky;
    logic [1:0] health;
    logic       busy;
    logic [4:0] level;

    modport master (
        output req_valid, req_x, req_y, req_health,
        input  req_ready, go_draw, brickx, bricky, health, busy, level
    );

    modport slave (
        input  req_valid, req_x, req_y, req_health,
        output req_ready, go_draw, brickx, bricky, health, busy, level
    );
endinterface

// File: rtl/brick_draw_queue.sv
// Brick redraw request queue and paced dispatcher feeding brick_draw.
// Optional `BRICKQ_COALESCE_EN: same-position push updates newest entry's health.
module brick_draw_queue #(
    parameter int DEPTH       = 8,
    parameter int DRAW_CYCLES = 1024
) (
    input logic               clk,
    input logic               resetn,
    brick_draw_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] FULL = 5'(DEPTH);
    localparam logic [19:0] CNT_LOAD = 20'(DRAW_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] h;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] last_ptr;
    logic [AW-1:0] wr_idx;
    logic [4:0]    level;
    logic [4:0]    level_n;
    logic [19:0]   cnt;
    state_t        state;
    state_t        state_n;
    logic          push;
    logic          pop;
    logic          coalesce;
    logic          alloc;
    logic          go_n;
    logic          busy_n;

    assign bus.req_ready = (level != FULL);
    assign bus.level     = level;

    assign push     = bus.req_valid & bus.req_ready;
    assign pop      = (state == IDLE) & (level != 5'd0);
    assign last_ptr = wr_ptr - AW'(1);

`ifdef BRICKQ_COALESCE_EN
    // Newest entry is only safe to rewrite if it is not leaving this cycle.
    assign coalesce = push & (level != 5'd0)
                    & ~(pop & (level == 5'd1))
                    & (bus.req_x == mem[last_ptr].x)
                    & (bus.req_y == mem[last_ptr].y);
`else
    assign coalesce = 1'b0;
`endif

    // Coalesced pushes rewrite the newest slot; x/y already match there.
    assign alloc  = push & ~coalesce;
    assign wr_idx = coalesce ? last_ptr : wr_ptr;

    // Occupancy after this cycle's allocate/pop.
    always_comb begin
        level_n = level + 5'(alloc) - 5'(pop);
    end

    // Entry storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_idx] <= '{x: bus.req_x, y: bus.req_y, h: bus.req_health};
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (alloc) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            level <= level_n;
        end
    end

    // Dispatcher state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    // Dispatcher next-state.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (level != 5'd0) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (cnt == 20'd0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Draw-window counter: loaded in ISSUE, runs down through WAIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                         cnt <= '0;
        else if (state == ISSUE)             cnt <= CNT_LOAD;
        else if (state == WAIT && cnt != '0) cnt <= cnt - 20'd1;
    end

    // Next values for the registered dispatcher outputs.
    always_comb begin
        go_n   = (state_n == ISSUE);
        busy_n = (state_n != IDLE) | (level_n != 5'd0);
    end

    // Registered outputs; brick fields only move when the head is popped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.go_draw <= 1'b0;
            bus.busy    <= 1'b0;
            bus.brickx  <= '0;
            bus.bricky  <= '0;
            bus.health  <= '0;
        end else begin
            bus.go_draw <= go_n;
            bus.busy    <= busy_n;
            if (pop) begin
                bus.brickx <= mem[rd_ptr].x;
                bus.bricky <= mem[rd_ptr].y;
                bus.health <= mem[rd_ptr].h;
            end
        end
    end

endmodule

// File: tb/tb_brick_draw_queue.sv
// Directed bench for brick_draw_queue: vector table plus multi-cycle sequences.
// Define BRICKQ_COALESCE_EN for both bench and design to check coalescing.
module tb_brick_draw_queue;

    localparam int D     = 32;
    localparam int DEPTH = 8;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] h;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [1:0] eh;
    } vec_t;

    typedef struct {
        logic [21:0] v;
        int          c;
    } pulse_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   maxlvl = 0;
    vec_t vec [20];
    pulse_t pulses [$];

    always #5 clk = ~clk;

    brick_draw_queue_if bus ();

    brick_draw_queue #(
        .DEPTH       (DEPTH),
        .DRAW_CYCLES (D)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.go_draw)
            pulses.push_back('{v: {bus.brickx, bus.bricky, bus.health}, c: cyc});
        if (int'(bus.level) > maxlvl) maxlvl = int'(bus.level);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [9:0] x, input logic [9:0] y,
                        input logic [1:0] h);
        bus.req_valid  = 1'b1;
        bus.req_x      = x;
        bus.req_y      = y;
        bus.req_health = h;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus.busy && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    function automatic logic [31:0] expv(input int i);
        return 32'({vec[i].ex, vec[i].ey, vec[i].eh});
    endfunction

    initial begin
        vec[0]  = '{10'd40,   10'd16,   2'd2, 10'd40,   10'd16,   2'd2};
        vec[1]  = '{10'd0,    10'd0,    2'd0, 10'd0,    10'd0,    2'd0};
        vec[2]  = '{10'd1023, 10'd1023, 2'd3, 10'd1023, 10'd1023, 2'd3};
        vec[3]  = '{10'd100,  10'd200,  2'd1, 10'd100,  10'd200,  2'd1};
        vec[4]  = '{10'd512,  10'd7,    2'd2, 10'd512,  10'd7,    2'd2};
        vec[5]  = '{10'd8,    10'd480,  2'd0, 10'd8,    10'd480,  2'd0};
        vec[6]  = '{10'd639,  10'd479,  2'd3, 10'd639,  10'd479,  2'd3};
        vec[7]  = '{10'd33,   10'd66,   2'd1, 10'd33,   10'd66,   2'd1};
        vec[8]  = '{10'd64,   10'd32,   2'd2, 10'd64,   10'd32,   2'd2};
        vec[9]  = '{10'd96,   10'd32,   2'd1, 10'd96,   10'd32,   2'd1};
        vec[10] = '{10'd128,  10'd32,   2'd0, 10'd128,  10'd32,   2'd0};
        vec[11] = '{10'd160,  10'd32,   2'd3, 10'd160,  10'd32,   2'd3};
        vec[12] = '{10'd192,  10'd48,   2'd2, 10'd192,  10'd48,   2'd2};
        vec[13] = '{10'd224,  10'd48,   2'd1, 10'd224,  10'd48,   2'd1};
        vec[14] = '{10'd256,  10'd48,   2'd0, 10'd256,  10'd48,   2'd0};
        vec[15] = '{10'd288,  10'd48,   2'd3, 10'd288,  10'd48,   2'd3};
        vec[16] = '{10'd320,  10'd64,   2'd1, 10'd320,  10'd64,   2'd1};
        vec[17] = '{10'd352,  10'd64,   2'd2, 10'd352,  10'd64,   2'd2};
        vec[18] = '{10'd384,  10'd64,   2'd0, 10'd384,  10'd64,   2'd0};
        vec[19] = '{10'd416,  10'd64,   2'd3, 10'd416,  10'd64,   2'd3};

        bus.req_valid  = 1'b0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_health = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_go",    32'(bus.go_draw),   32'd0);
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_level", 32'(bus.level),     32'd0);
        check("rst_brick", 32'({bus.brickx, bus.bricky, bus.health}), 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Single request latency and busy duration
        pulses.delete();
        push(10'd40, 10'd16, 2'd2);
        check("single_lvl1", 32'(bus.level),   32'd1);
        check("single_go0",  32'(bus.go_draw), 32'd0);
        check("single_busy", 32'(bus.busy),    32'd1);
        @(posedge clk);
        #1;
        check("single_go1",  32'(bus.go_draw), 32'd1);
        check("single_data", 32'({bus.brickx, bus.bricky, bus.health}),
              32'({10'd40, 10'd16, 2'd2}));
        check("single_lvl0", 32'(bus.level),   32'd0);
        @(posedge clk);
        #1;
        check("single_go_off", 32'(bus.go_draw), 32'd0);
        repeat (D - 1) @(posedge clk);
        #1;
        check("single_busy_hold", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        check("single_busy_fall", 32'(bus.busy), 32'd0);
        check("single_npulse", 32'(pulses.size()), 32'd1);
        check("single_hold", 32'({bus.brickx, bus.bricky, bus.health}),
              32'({10'd40, 10'd16, 2'd2}));

        // Full: dispatcher busy with a warm-up entry, then 9 back-to-back pushes
        pulses.delete();
        push(10'd1, 10'd1, 2'd1);
        for (int i = 0; i < 9; i++) begin
            bus.req_valid  = 1'b1;
            bus.req_x      = (i < 8) ? vec[i].x : 10'd999;
            bus.req_y      = (i < 8) ? vec[i].y : 10'd999;
            bus.req_health = (i < 8) ? vec[i].h : 2'd3;
            check($sformatf("full_ready%0d", i), 32'(bus.req_ready),
                  (i < 8) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        check("full_level", 32'(bus.level), 32'd8);
        wait_idle(12 * (D + 2));
        check("full_npulse", 32'(pulses.size()), 32'd9);
        for (int i = 0; i < 8; i++) begin
            if (pulses.size() > i + 1) begin
                check($sformatf("full_data%0d", i), 32'(pulses[i + 1].v), expv(i));
                check($sformatf("full_gap%0d", i),
                      32'(pulses[i + 1].c - pulses[i].c), 32'(D + 2));
            end
        end

        // Wrap: trickle 20 requests one per window
        pulses.delete();
        maxlvl = 0;
        for (int i = 0; i < 20; i++) begin
            push(vec[i].x, vec[i].y, vec[i].h);
            wait_idle(D + 10);
            check($sformatf("wrap_n%0d", i), 32'(pulses.size()), 32'(i + 1));
            if (pulses.size() > i)
                check($sformatf("wrap_data%0d", i), 32'(pulses[i].v), expv(i));
        end
        check("wrap_maxlvl", 32'(maxlvl), 32'd1);

        // Simultaneous push and pop with level 3
        pulses.delete();
        push(10'd5, 10'd5, 2'd0);
        push(vec[3].x, vec[3].y, vec[3].h);
        push(vec[4].x, vec[4].y, vec[4].h);
        push(vec[5].x, vec[5].y, vec[5].h);
        repeat (D - 1) @(posedge clk);
        #1;
        check("simul_pre_lvl", 32'(bus.level),   32'd3);
        check("simul_pre_go",  32'(bus.go_draw), 32'd0);
        push(vec[6].x, vec[6].y, vec[6].h);
        check("simul_go",   32'(bus.go_draw), 32'd1);
        check("simul_lvl",  32'(bus.level),   32'd3);
        check("simul_head", 32'({bus.brickx, bus.bricky, bus.health}), expv(3));
        wait_idle(6 * (D + 2));
        check("simul_npulse", 32'(pulses.size()), 32'd5);
        for (int i = 0; i < 4; i++) begin
            if (pulses.size() > i + 1)
                check($sformatf("simul_data%0d", i), 32'(pulses[i + 1].v),
                      expv(i + 3));
        end

        // Same-position pushes while busy
        pulses.delete();
        push(10'd5, 10'd5, 2'd0);
        push(10'd8, 10'd8, 2'd3);
        push(10'd8, 10'd8, 2'd1);
`ifdef BRICKQ_COALESCE_EN
        check("coal_level", 32'(bus.level), 32'd1);
        wait_idle(4 * (D + 2));
        check("coal_npulse", 32'(pulses.size()), 32'd2);
        if (pulses.size() > 1)
            check("coal_data", 32'(pulses[1].v), 32'({10'd8, 10'd8, 2'd1}));
`else
        check("dup_level", 32'(bus.level), 32'd2);
        wait_idle(4 * (D + 2));
        check("dup_npulse", 32'(pulses.size()), 32'd3);
        if (pulses.size() > 2) begin
            check("dup_data0", 32'(pulses[1].v), 32'({10'd8, 10'd8, 2'd3}));
            check("dup_data1", 32'(pulses[2].v), 32'({10'd8, 10'd8, 2'd1}));
        end
`endif

        // Reset mid-WAIT with entries still queued
        pulses.delete();
        push(10'd1, 10'd2, 2'd3);
        push(10'd4, 10'd5, 2'd1);
        push(10'd6, 10'd7, 2'd2);
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy",  32'(bus.busy),  32'd1);
        check("mid_level", 32'(bus.level), 32'd2);
        resetn = 1'b0;
        #1;
        check("arst_go",    32'(bus.go_draw),   32'd0);
        check("arst_level", 32'(bus.level),     32'd0);
        check("arst_ready", 32'(bus.req_ready), 32'd1);
        check("arst_busy",  32'(bus.busy),      32'd0);
        check("arst_brick", 32'({bus.brickx, bus.bricky, bus.health}), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (3 * (D + 2)) @(posedge clk);
        #1;
        check("arst_npulse", 32'(pulses.size()), 32'd1);
        check("arst_idle",   32'(bus.busy),      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
